// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue: default widths, the bubble value
// and the {pc, instr} entry layout used by the queue and its storage.
package if_id_queue_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 4;

    localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

    // pc sits in the upper bits and instr in the lower bits of every stored entry
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } entry_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: DEPTH x WIDTH register array,
// one synchronous write port and one asynchronous read port, contents not reset.
module if_id_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry {pc, instr} FIFO with valid/ready on both sides.
// Optional zero-latency pass-through when empty is enabled by defining IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_instr,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic              w_live;
    logic              w_empty;
    logic              w_full;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic [ENT_W-1:0]  w_head;
    logic [ADDR_W-1:0] w_head_pc;
    logic [DATA_W-1:0] w_head_instr;

    // Reset is folded in so in_ready stays low while rst_n_in is asserted
    assign w_live  = rst_n_in & rdy_in & ~flush_in;
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    always_comb begin
        w_bypass = 1'b0;
`ifdef IF_ID_QUEUE_BYPASS_EN
        w_bypass = w_live & w_empty & in_valid;
`endif
    end

    assign in_ready  = w_live & ~w_full;
    assign out_valid = (w_live & ~w_empty) | w_bypass;

    // A bypassed entry that ID takes immediately is never written and never popped
    assign w_push = in_valid & in_ready & ~(w_bypass & out_ready);
    assign w_pop  = out_valid & out_ready & ~w_bypass;

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .i_clk   (clk_in),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({in_pc, in_instr}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign w_head_pc    = w_head[ENT_W-1 -: ADDR_W];
    assign w_head_instr = w_head[DATA_W-1:0];

    always_comb begin
        out_pc    = ADDR_W'(ZERO_WORD);
        out_instr = DATA_W'(ZERO_WORD);
        if (w_bypass) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end else if (out_valid) begin
            out_pc    = w_head_pc;
            out_instr = w_head_instr;
        end
    end

    // Flush rewinds the write pointer onto the read pointer so no stale entry resurfaces
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                r_wr_ptr <= r_rd_ptr;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    assign count_out = r_count;

endmodule
